// File: rtl/ranger_array.sv
// Round-robin multi-channel HC-SR04 front end: pings one ranger at a time, measures each
// echo width in ticks, and keeps a per-channel moving average mapped to an intensity level.
module ranger_array #(
  parameter int TICK_DIV      = 40,
  parameter int N_CH          = 4,
  parameter int W             = 16,
  parameter int DEPTH_LOG2    = 3,
  parameter int TRIG_TICKS    = 10,
  parameter int TIMEOUT_TICKS = 30000,
  parameter int PERIOD_TICKS  = 60000,
  parameter int STEP_LOG2     = 9,
  parameter int LEVELS        = 8,
  localparam int CH_W         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [N_CH-1:0]   echo,
  output logic [N_CH-1:0]   trig,
  output logic [N_CH*W-1:0] raw,
  output logic [N_CH*W-1:0] avg,
  output logic [N_CH*4-1:0] intensity,
  output logic              meas_valid,
  output logic [CH_W-1:0]   meas_ch,
  output logic              meas_timeout
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PER_W = $clog2(PERIOD_TICKS + 1);
  localparam int TO_W  = $clog2(TIMEOUT_TICKS + 1);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PTR_W = (DEPTH_LOG2 > 0) ? DEPTH_LOG2 : 1;
  localparam int SUM_W = W + DEPTH_LOG2;
  localparam logic [SUM_W-1:0] SUM_INIT = SUM_W'({W{1'b1}}) << DEPTH_LOG2;

  typedef enum logic [2:0] {S_IDLE, S_TRIG, S_WAIT_RISE, S_MEASURE, S_GAP} state_t;

  // Tick enable: one clk out of every TICK_DIV.
  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick = (div_cnt == DIV_W'(TICK_DIV - 1));

  // NOTE: sequential state always uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  // Two-flop synchronizer, plus a tick-rate copy used to detect edges between ticks.
  logic [N_CH-1:0] echo_m, echo_s, echo_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      echo_m <= '0;
      echo_s <= '0;
      echo_q <= '0;
    end else begin
      echo_m <= echo;
      echo_s <= echo_m;
      if (tick) echo_q <= echo_s;
    end
  end

  state_t          state;
  logic [CH_W-1:0] ch;
  logic [PER_W-1:0] per_cnt;
  logic [TO_W-1:0] to_cnt, to_next;
  logic [W-1:0]    cnt, result;
  logic [W-1:0]    raw_r [N_CH];
  logic            cur, rise, to_hit;
  logic            fin, fin_to;
  logic [W-1:0]    fin_val;

  assign cur     = echo_s[ch];
  assign rise    = echo_s[ch] & ~echo_q[ch];
  assign to_next = to_cnt + 1'b1;
  assign to_hit  = (to_next == TO_W'(TIMEOUT_TICKS));

  // End-of-measurement decision; a falling edge wins over a timeout on the same tick.
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    fin     = 1'b0;
    fin_to  = 1'b0;
    fin_val = cnt;
    if (tick) begin
      case (state)
        S_WAIT_RISE: if (to_hit) begin
          fin     = 1'b1;
          fin_to  = 1'b1;
          fin_val = '1;
        end
        S_MEASURE: if (!cur) begin
          fin = 1'b1;
        end else if (to_hit) begin
          fin     = 1'b1;
          fin_to  = 1'b1;
          fin_val = '1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      ch           <= '0;
      per_cnt      <= '0;
      to_cnt       <= '0;
      cnt          <= '0;
      result       <= '1;
      trig         <= '0;
      meas_valid   <= 1'b0;
      meas_timeout <= 1'b0;
      meas_ch      <= '0;
      for (int c = 0; c < N_CH; c++) raw_r[c] <= '1;
    end else begin
      meas_valid   <= 1'b0;
      meas_timeout <= 1'b0;
      if (fin) begin
        raw_r[ch]    <= fin_val;
        result       <= fin_val;
        meas_valid   <= 1'b1;
        meas_timeout <= fin_to;
        meas_ch      <= ch;
        state        <= S_GAP;
      end
      if (tick) begin
        // per_cnt holds the tick index relative to the trig rise of the current cycle.
        if (state != S_IDLE) per_cnt <= per_cnt + 1'b1;
        case (state)
          S_IDLE: if (enable) begin
            state    <= S_TRIG;
            trig[ch] <= 1'b1;
            per_cnt  <= PER_W'(1);
          end
          S_TRIG: if (per_cnt == PER_W'(TRIG_TICKS)) begin
            trig   <= '0;
            to_cnt <= '0;
            state  <= S_WAIT_RISE;
          end
          S_WAIT_RISE: begin
            to_cnt <= to_next;
            if (!fin && rise) begin
              cnt   <= W'(1);
              state <= S_MEASURE;
            end
          end
          S_MEASURE: begin
            to_cnt <= to_next;
            if (!fin && cnt != '1) cnt <= cnt + 1'b1;
          end
          S_GAP: if (per_cnt >= PER_W'(PERIOD_TICKS - 1)) begin
            ch    <= (ch == CH_W'(N_CH - 1)) ? '0 : ch + 1'b1;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Moving-average filter, updated the clk after meas_valid.
  logic [W-1:0]     ring [N_CH][DEPTH];
  logic [SUM_W-1:0] sum  [N_CH];
  logic [PTR_W-1:0] ptr  [N_CH];

  // NOTE: the ring is reset on purpose: all-ones history makes a fresh channel read as
  // far away, so it must be flops rather than an unreset RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < N_CH; c++) begin
        sum[c] <= SUM_INIT;
        ptr[c] <= '0;
        for (int i = 0; i < DEPTH; i++) ring[c][i] <= '1;
      end
    end else if (meas_valid) begin
      sum[meas_ch]               <= sum[meas_ch] - SUM_W'(ring[meas_ch][ptr[meas_ch]])
                                    + SUM_W'(result);
      ring[meas_ch][ptr[meas_ch]] <= result;
      ptr[meas_ch]               <= (ptr[meas_ch] == PTR_W'(DEPTH - 1)) ? '0
                                    : ptr[meas_ch] + 1'b1;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_out
    logic [W-1:0] avg_c, k_c;

    assign avg_c                = W'(sum[c] >> DEPTH_LOG2);
    assign k_c                  = (avg_c - 1'b1) >> STEP_LOG2;
    assign raw[c*W +: W]        = raw_r[c];
    assign avg[c*W +: W]        = avg_c;
    assign intensity[c*4 +: 4]  = (avg_c == '0 || k_c >= W'(LEVELS)) ? 4'd0
                                  : 4'(W'(LEVELS) - k_c);
  end

endmodule
